// File: rtl/hack_alu.sv
// rtl/hack_alu.sv - Registered 16-bit Hack ALU with zero/negative flags
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ALUoutput,
  output logic             isZero,
  output logic             isNeg,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_xa;
  logic [WIDTH-1:0] w_xb;
  logic [WIDTH-1:0] w_ya;
  logic [WIDTH-1:0] w_yb;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_out;

  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_neg;
  logic             r_valid;

  always_comb begin
    w_xa  = zx ? '0 : x;
    w_xb  = nx ? ~w_xa : w_xa;
    w_ya  = zy ? '0 : y;
    w_yb  = ny ? ~w_ya : w_ya;
    // Carry-out of the add is intentionally dropped.
    w_r   = f ? (w_xb + w_yb) : (w_xb & w_yb);
    w_out = no ? ~w_r : w_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out  <= w_out;
        r_zero <= (w_out == '0);
        r_neg  <= w_out[WIDTH-1];
      end
    end
  end

  assign ALUoutput = r_out;
  assign isZero    = r_zero;
  assign isNeg     = r_neg;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_hack_alu.sv
// tb/tb_hack_alu.sv - Self-checking bench for hack_alu
module tb_hack_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic        in_valid;
  logic [15:0] ALUoutput;
  logic        isZero, isNeg, out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hack_alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .in_valid(in_valid), .ALUoutput(ALUoutput),
    .isZero(isZero), .isNeg(isNeg), .out_valid(out_valid)
  );

  // Code packing: {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] model(input logic [5:0] c, input logic [15:0] a,
                                        input logic [15:0] b);
    int xv, yv, rv;
    xv = c[5] ? 0 : int'(a);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : int'(b);
    if (c[2]) yv = 65535 - yv;
    if (c[1]) rv = (xv + yv) % 65536;
    else      rv = xv & yv;
    if (c[0]) rv = 65535 - rv;
    return rv[15:0];
  endfunction

  logic [15:0] m_out;
  logic        m_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out   <= 16'h0000;
      m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) m_out <= model({zx, nx, zy, ny, f, no}, x, y);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("model_valid", {15'd0, out_valid}, {15'd0, m_valid});
      check("model_out",   ALUoutput, m_out);
      check("model_zero",  {15'd0, isZero}, {15'd0, m_out == 16'h0000});
      check("model_neg",   {15'd0, isNeg},  {15'd0, m_out[15]});
    end
  end

  task automatic drive(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic v);
    @(negedge clk);
    {zx, nx, zy, ny, f, no} = c;
    x = a;
    y = b;
    in_valid = v;
  endtask

  task automatic run(input string name, input logic [5:0] c, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] exp);
    drive(c, a, b, 1'b1);
    @(posedge clk);
    #1;
    check({name, "_out"},   ALUoutput, exp);
    check({name, "_zero"},  {15'd0, isZero}, {15'd0, exp == 16'h0000});
    check({name, "_neg"},   {15'd0, isNeg},  {15'd0, exp[15]});
    check({name, "_valid"}, {15'd0, out_valid}, 16'd1);
  endtask

  typedef struct {
    string       name;
    logic [5:0]  code;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{"zero",  6'b101010, 16'hAAAA, 16'h5555, 16'h0000};
    vecs[1]  = '{"one",   6'b111111, 16'hAAAA, 16'h5555, 16'h0001};
    vecs[2]  = '{"m_one", 6'b111010, 16'hAAAA, 16'h5555, 16'hFFFF};
    vecs[3]  = '{"x",     6'b001100, 16'hAAAA, 16'h5555, 16'hAAAA};
    vecs[4]  = '{"y",     6'b110000, 16'hAAAA, 16'h5555, 16'h5555};
    vecs[5]  = '{"not_x", 6'b001101, 16'hAAAA, 16'h5555, 16'h5555};
    vecs[6]  = '{"not_y", 6'b110001, 16'hAAAA, 16'h5555, 16'hAAAA};
    vecs[7]  = '{"neg_x", 6'b001111, 16'hAAAA, 16'h5555, 16'h5556};
    vecs[8]  = '{"neg_y", 6'b110011, 16'hAAAA, 16'h5555, 16'hAAAB};
    vecs[9]  = '{"x_p1",  6'b011111, 16'h000F, 16'h00F0, 16'h0010};
    vecs[10] = '{"y_p1",  6'b110111, 16'h000F, 16'h00F0, 16'h00F1};
    vecs[11] = '{"x_m1",  6'b001110, 16'h000F, 16'h00F0, 16'h000E};
    vecs[12] = '{"y_m1",  6'b110010, 16'h000F, 16'h00F0, 16'h00EF};
    vecs[13] = '{"x_py",  6'b000010, 16'h000F, 16'h00F0, 16'h00FF};
    vecs[14] = '{"x_my",  6'b010011, 16'h000F, 16'h00F0, 16'hFF1F};
    vecs[15] = '{"y_mx",  6'b000111, 16'h000F, 16'h00F0, 16'h00E1};
    vecs[16] = '{"x_and", 6'b000000, 16'h000F, 16'h00F8, 16'h0008};
    vecs[17] = '{"x_or",  6'b010101, 16'h000F, 16'h00F0, 16'h00FF};
    vecs[18] = '{"carry", 6'b000010, 16'hFFFF, 16'h0001, 16'h0000};

    reset = 1'b1;
    x = 16'h0; y = 16'h0;
    {zx, nx, zy, ny, f, no} = 6'b0;
    in_valid = 1'b0;
    #12;
    check("rst_out",   ALUoutput, 16'h0000);
    check("rst_zero",  {15'd0, isZero}, 16'd1);
    check("rst_neg",   {15'd0, isNeg}, 16'd0);
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Consecutive runs keep in_valid high every cycle: back-to-back coverage.
    foreach (vecs[i]) run(vecs[i].name, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Hold: in_valid low while operands and controls toggle.
    for (int i = 0; i < 3; i++) begin
      drive(6'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      @(posedge clk);
      #1;
      check("hold_out",   ALUoutput, 16'h0000);
      check("hold_zero",  {15'd0, isZero}, 16'd1);
      check("hold_valid", {15'd0, out_valid}, 16'd0);
    end

    // A few random codes checked by the model process.
    for (int i = 0; i < 20; i++) drive(6'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

    run("pre_rst", 6'b111010, 16'h1234, 16'h5678, 16'hFFFF);
    // Capture pending at the next edge; reset lands between edges.
    drive(6'b001100, 16'h8001, 16'h0000, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out",   ALUoutput, 16'h0000);
    check("arst_zero",  {15'd0, isZero}, 16'd1);
    check("arst_neg",   {15'd0, isNeg}, 16'd0);
    check("arst_valid", {15'd0, out_valid}, 16'd0);
    @(posedge clk);
    #1;
    check("arst_held",  ALUoutput, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    run("post_rst", 6'b001100, 16'h8001, 16'h0000, 16'h8001);

    drive(6'b000000, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
